// File: rtl/spectrum_band_smoother_if.sv
// Bin stream into the band smoother: valid/ready handshake carrying one
// signed FFT bin per transfer plus an end-of-frame marker.
interface spectrum_band_smoother_if;
    logic        bin_valid;
    logic        bin_ready;
    logic [23:0] bin_data;
    logic        bin_last;

    modport master (
        output bin_valid,
        output bin_data,
        output bin_last,
        input  bin_ready
    );

    modport slave (
        input  bin_valid,
        input  bin_data,
        input  bin_last,
        output bin_ready
    );
endinterface

// File: rtl/spectrum_band_smoother.sv
// Folds a serial FFT bin stream into 16 peak-per-band heights and applies
// peak-hold with exponential decay, one band per cycle after each frame.
module spectrum_band_smoother #(
    parameter int BINS_PER_BAND = 4,
    parameter int DECAY_SHIFT   = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    spectrum_band_smoother_if.slave     bin_if,
    output logic [23:0]                 f0,
    output logic [23:0]                 f1,
    output logic [23:0]                 f2,
    output logic [23:0]                 f3,
    output logic [23:0]                 f4,
    output logic [23:0]                 f5,
    output logic [23:0]                 f6,
    output logic [23:0]                 f7,
    output logic [23:0]                 f8,
    output logic [23:0]                 f9,
    output logic [23:0]                 f10,
    output logic [23:0]                 f11,
    output logic [23:0]                 f12,
    output logic [23:0]                 f13,
    output logic [23:0]                 f14,
    output logic [23:0]                 f15,
    output logic                        done
);
    localparam int BIN_W = (BINS_PER_BAND > 1) ? $clog2(BINS_PER_BAND) : 1;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BINS_PER_BAND - 1);

    typedef enum logic [1:0] {ST_ACCUM, ST_UPDATE, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        band_reg;
    logic [3:0]        k_reg;
    logic [BIN_W-1:0]  bin_cnt_reg;
    logic [23:0]       acc_reg  [16];
    logic [23:0]       disp_reg [16];

    logic              xfer;
    logic              frame_end;
    logic [23:0]       mag;
    logic [23:0]       disp_sel;
    logic [23:0]       decay_step;
    logic [23:0]       dec;
    logic [23:0]       upd_val;

    assign xfer      = bin_if.bin_valid && (state_reg == ST_ACCUM);
    assign frame_end = xfer && (bin_if.bin_last ||
                       (band_reg == 4'd15 && bin_cnt_reg == LAST_BIN));

    // -8388608 has no positive counterpart in 24 bits, so it clamps.
    always_comb begin
        mag = bin_if.bin_data;
        if (bin_if.bin_data[23]) begin
            if (bin_if.bin_data[22:0] == 23'd0)
                mag = 24'h7FFFFF;
            else
                mag = ~bin_if.bin_data + 24'd1;
        end
    end

    // Decay of the band being updated; always at least 1 so bars reach zero.
    always_comb begin
        disp_sel   = disp_reg[k_reg];
        decay_step = disp_sel >> DECAY_SHIFT;
        if (decay_step == 24'd0 && disp_sel != 24'd0)
            decay_step = 24'd1;
        dec     = disp_sel - decay_step;
        upd_val = (acc_reg[k_reg] > dec) ? acc_reg[k_reg] : dec;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= ST_ACCUM;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_ACCUM:  if (frame_end) state_next = ST_UPDATE;
            ST_UPDATE: if (k_reg == 4'd15) state_next = ST_DONE;
            default:   state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        bin_if.bin_ready = (state_reg == ST_ACCUM);
        done             = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            band_reg    <= '0;
            bin_cnt_reg <= '0;
            k_reg       <= '0;
            for (int i = 0; i < 16; i++) begin
                acc_reg[i]  <= '0;
                disp_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (xfer) begin
                        if (mag > acc_reg[band_reg])
                            acc_reg[band_reg] <= mag;
                        if (frame_end) begin
                            band_reg    <= '0;
                            bin_cnt_reg <= '0;
                        end else if (bin_cnt_reg == LAST_BIN) begin
                            bin_cnt_reg <= '0;
                            band_reg    <= band_reg + 4'd1;
                        end else begin
                            bin_cnt_reg <= bin_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    disp_reg[k_reg] <= upd_val;
                    acc_reg[k_reg]  <= '0;
                    k_reg           <= k_reg + 4'd1;
                end
                default: begin
                    band_reg    <= '0;
                    bin_cnt_reg <= '0;
                    k_reg       <= '0;
                end
            endcase
        end
    end

    assign f0  = disp_reg[0];
    assign f1  = disp_reg[1];
    assign f2  = disp_reg[2];
    assign f3  = disp_reg[3];
    assign f4  = disp_reg[4];
    assign f5  = disp_reg[5];
    assign f6  = disp_reg[6];
    assign f7  = disp_reg[7];
    assign f8  = disp_reg[8];
    assign f9  = disp_reg[9];
    assign f10 = disp_reg[10];
    assign f11 = disp_reg[11];
    assign f12 = disp_reg[12];
    assign f13 = disp_reg[13];
    assign f14 = disp_reg[14];
    assign f15 = disp_reg[15];
endmodule

// File: tb/tb_spectrum_band_smoother.sv
// Directed frame vectors for spectrum_band_smoother with hand-computed band
// heights, plus sequences for backpressure and reset during UPDATE.
module tb_spectrum_band_smoother;
    logic        clk;
    logic        reset_n;
    logic [23:0] f_o [16];
    logic        done;

    spectrum_band_smoother_if bif ();

    spectrum_band_smoother #(.BINS_PER_BAND(4), .DECAY_SHIFT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bin_if  (bif.slave),
        .f0  (f_o[0]),  .f1  (f_o[1]),  .f2  (f_o[2]),  .f3  (f_o[3]),
        .f4  (f_o[4]),  .f5  (f_o[5]),  .f6  (f_o[6]),  .f7  (f_o[7]),
        .f8  (f_o[8]),  .f9  (f_o[9]),  .f10 (f_o[10]), .f11 (f_o[11]),
        .f12 (f_o[12]), .f13 (f_o[13]), .f14 (f_o[14]), .f15 (f_o[15]),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                 do_reset;
        logic [23:0]        fill;
        int                 sp_idx;
        logic [23:0]        sp_val;
        int                 last_idx;
        bit                 use_last;
        logic [15:0][23:0]  exp_f;
    } vec_t;

    vec_t vecs [16];
    int   n_vec;
    int   errs;
    int   done_cnt;
    bit   done_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // done must never be high two cycles in a row
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && done_prev) begin
            errs++;
            $display("FAIL done_consecutive: got 1 expected 0");
        end
        done_prev = done;
    end

    function automatic vec_t mkv(input bit rst, input logic [23:0] fill, input int sp_idx,
                                 input logic [23:0] sp_val, input int last_idx, input bit use_last,
                                 input logic [23:0] e_all, input int n_lo, input logic [23:0] e_lo,
                                 input int i1, input logic [23:0] v1, input int i2, input logic [23:0] v2);
        vec_t v;
        v.do_reset = rst;
        v.fill     = fill;
        v.sp_idx   = sp_idx;
        v.sp_val   = sp_val;
        v.last_idx = last_idx;
        v.use_last = use_last;
        for (int i = 0; i < 16; i++) v.exp_f[i] = (i < n_lo) ? e_lo : e_all;
        if (i1 >= 0) v.exp_f[i1] = v1;
        if (i2 >= 0) v.exp_f[i2] = v2;
        return v;
    endfunction

    task automatic apply_reset();
        reset_n       = 1'b0;
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
        bif.bin_data  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_bin(input logic [23:0] d, input logic l);
        int guard = 0;
        bif.bin_valid = 1'b1;
        bif.bin_data  = d;
        bif.bin_last  = l;
        while (!bif.bin_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
    endtask

    // Entered in cycle T+1 after the frame-ending transfer at T.
    task automatic wait_done(input string nm);
        int c = 1;
        int ready_hi = 0;
        while (c <= 40 && !done) begin
            if (bif.bin_ready) ready_hi++;
            @(negedge clk);
            c++;
        end
        if (bif.bin_ready) ready_hi++;
        chk({nm, "_done_latency"}, 32'(c), 32'd17);
        chk({nm, "_ready_low"}, 32'(ready_hi), 32'd0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, "_ready_back"}, {31'd0, bif.bin_ready}, 32'd1);
    endtask

    task automatic chk_all_f(input string nm, input logic [23:0] e);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_f%0d", nm, i), {8'd0, f_o[i]}, {8'd0, e});
    endtask

    initial begin
        int d0;
        n_vec         = 0;
        errs          = 0;
        done_cnt      = 0;
        done_prev     = 1'b0;
        reset_n       = 1'b0;
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
        bif.bin_data  = '0;

        vecs[0]  = mkv(1, 24'h000100, -1, 0,           63, 1, 24'h000100, 0, 0,    -1, 0,           -1, 0);
        vecs[1]  = mkv(1, 24'h0,       5, 24'h800000,  63, 0, 24'h0,      0, 0,     1, 24'h7FFFFF,  -1, 0);
        vecs[2]  = mkv(0, 24'h0,      12, 24'd800,     63, 0, 24'h0,      0, 0,     1, 24'h700000,   3, 24'd800);
        vecs[3]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     1, 24'h620000,   3, 24'd700);
        vecs[4]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     1, 24'h55C000,   3, 24'd613);
        vecs[5]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     1, 24'h4B0800,   3, 24'd537);
        vecs[6]  = mkv(1, 24'h0,      12, 24'hFFFFFB,  63, 0, 24'h0,      0, 0,     3, 24'd5,       -1, 0);
        vecs[7]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd4,       -1, 0);
        vecs[8]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd3,       -1, 0);
        vecs[9]  = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd2,       -1, 0);
        vecs[10] = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd1,       -1, 0);
        vecs[11] = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd0,       -1, 0);
        vecs[12] = mkv(0, 24'h0,      -1, 0,           63, 0, 24'h0,      0, 0,     3, 24'd0,       -1, 0);
        vecs[13] = mkv(0, 24'd1000,   -1, 0,           63, 0, 24'd1000,   0, 0,    -1, 0,           -1, 0);
        vecs[14] = mkv(0, 24'd1000,   -1, 0,            9, 1, 24'd875,    3, 24'd1000, -1, 0,       -1, 0);
        vecs[15] = mkv(0, 24'hFFFFFF,  0, 24'd2000,    63, 0, 24'd766,    3, 24'd875,   0, 24'd2000, -1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, bif.bin_ready}, 32'd1);
        chk_all_f("rst", 24'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            if (vecs[v].do_reset) apply_reset();
            d0 = done_cnt;
            for (int i = 0; i <= vecs[v].last_idx; i++)
                send_bin((i == vecs[v].sp_idx) ? vecs[v].sp_val : vecs[v].fill,
                         vecs[v].use_last && (i == vecs[v].last_idx));
            wait_done($sformatf("v%0d", v));
            chk($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), 32'd1);
            for (int i = 0; i < 16; i++)
                chk($sformatf("v%0d_f%0d", v, i), {8'd0, f_o[i]}, {8'd0, vecs[v].exp_f[i]});
            $display("vector %0d: %0d bins, f0=0x%0h f1=0x%0h f3=0x%0h", v,
                     vecs[v].last_idx + 1, f_o[0], f_o[1], f_o[3]);
        end

        // Backpressure: bins offered while bin_ready is low must be dropped
        apply_reset();
        for (int i = 0; i < 64; i++) send_bin(24'h0, 1'b0);
        begin
            int c = 0;
            while (!bif.bin_ready && c < 40) begin
                bif.bin_valid = 1'b1;
                bif.bin_last  = 1'b1;
                bif.bin_data  = 24'h7000 + 24'(c);
                @(negedge clk);
                c++;
            end
            chk("bp_stall_cycles", 32'(c), 32'd17);
        end
        send_bin(24'd300, 1'b0);
        for (int i = 1; i < 64; i++) send_bin(24'h0, i == 63);
        wait_done("bp");
        chk("bp_f0", {8'd0, f_o[0]}, 32'd300);
        for (int i = 1; i < 16; i++)
            chk($sformatf("bp_f%0d", i), {8'd0, f_o[i]}, 32'd0);
        $display("backpressure: f0=0x%0h f1=0x%0h", f_o[0], f_o[1]);

        // Reset asserted while UPDATE is at band 7
        for (int i = 0; i < 64; i++) send_bin(24'd500, i == 63);
        repeat (7) @(negedge clk);
        d0 = done_cnt;
        chk("mid_f6_written", {8'd0, f_o[6]}, 32'd500);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk_all_f("mid_rst", 24'h0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        for (int i = 0; i < 64; i++) send_bin(24'h000123, 1'b0);
        wait_done("post_rst");
        chk("post_rst_done_count", 32'(done_cnt - d0), 32'd1);
        chk_all_f("post_rst", 24'h000123);
        $display("reset mid-update: f0=0x%0h f15=0x%0h", f_o[0], f_o[15]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end
endmodule
